// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared constants, UART state encoding and IO decode helper
package mem_bus_ctrl_pkg;

    localparam int IO_PAGE_BIT      = 22;
    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DATA_BIT = 1;
    localparam int IO_UART_STAT_BIT = 2;
    localparam int IO_CYCLES_BIT    = 3;

    typedef enum logic {
        UART_IDLE = 1'b0,
        UART_SEND = 1'b1
    } uart_state_e;

    // An IO register is hit only when its one-hot bit is the sole bit set
    function automatic logic io_hit(input logic [3:0] sel, input int unsigned bit_idx);
        return sel == (4'b0001 << bit_idx);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - core memory port bundle with master/slave views
interface mem_bus_ctrl_if;

    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    modport master (
        output mem_addr,
        output mem_rstrb,
        output mem_wdata,
        output mem_wmask,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rstrb,
        input  mem_wdata,
        input  mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_ctrl_uart_tx.sv
// rtl/mem_bus_ctrl_uart_tx.sv - 8N1 UART transmitter, one bit every CLK_FREQ/BAUD cycles
module uart_tx
    import mem_bus_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       TXD
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;

    // State and datapath registers; shift register idles all-ones so TXD rests high
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next state: load {stop,data,start} on start, then shift one bit per baud period
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            UART_IDLE: begin
                if (start) begin
                    shift_d = {1'b1, data, 1'b0};
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 4'd9;
                    state_d = UART_SEND;
                end
            end
            UART_SEND: begin
                if (baud_q == '0) begin
                    if (bit_q == 4'd0) begin
                        state_d = UART_IDLE;
                    end else begin
                        shift_d = {1'b1, shift_q[9:1]};
                        baud_d  = BAUD_RELOAD;
                        bit_d   = bit_q - 4'd1;
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Outputs: TXD comes straight from a flop so the line never glitches
    always_comb begin
        busy = (state_q == UART_SEND);
        TXD  = shift_q[0];
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - word RAM plus LED/UART/cycle-counter IO page behind the core memory port
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter     INIT_FILE = "",
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 115200
) (
    input  logic             CLK,
    input  logic             RESET,
    mem_bus_ctrl_if.slave    bus,
    output logic [3:0]       LEDS,
    output logic             TXD
);

    localparam int AW = $clog2(NUM_WORDS);

    logic [31:0]   ram [NUM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_io;
    logic [3:0]    io_sel;
    logic          io_wr;
    logic [31:0]   io_rdata;
    logic          uart_start;
    logic          uart_busy;

    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    leds_q, leds_d;
    logic [31:0]   cycles_q, cycles_d;

    logic          unused_bits;

    assign ram_idx     = bus.mem_addr[AW+1:2];
    assign is_io       = bus.mem_addr[IO_PAGE_BIT];
    assign io_sel      = bus.mem_addr[5:2];
    assign unused_bits = ^bus.mem_addr;

    // Byte-lane stores into the RAM; contents survive reset
    always_ff @(posedge CLK) begin
        if (!is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_wmask[i]) begin
                    ram[ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // IO page read mux and write strobes; ambiguous selects read zero and drop writes
    always_comb begin
        io_rdata   = '0;
        io_wr      = is_io & bus.mem_wmask[0];
        uart_start = io_wr & io_hit(io_sel, IO_UART_DATA_BIT);
        if (io_hit(io_sel, IO_LEDS_BIT)) begin
            io_rdata = {28'b0, leds_q};
        end else if (io_hit(io_sel, IO_UART_STAT_BIT)) begin
            io_rdata = {31'b0, uart_busy};
        end else if (io_hit(io_sel, IO_CYCLES_BIT)) begin
            io_rdata = cycles_q;
        end
    end

    // Next values: read data captured on strobe (old RAM word wins over a same-cycle store)
    always_comb begin
        rdata_d  = rdata_q;
        leds_d   = leds_q;
        cycles_d = cycles_q + 32'd1;
        if (bus.mem_rstrb) begin
            rdata_d = is_io ? io_rdata : ram[ram_idx];
        end
        if (io_wr && io_hit(io_sel, IO_LEDS_BIT)) begin
            leds_d = bus.mem_wdata[3:0];
        end
    end

    // Bus-side registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_q  <= '0;
            leds_q   <= '0;
            cycles_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            leds_q   <= leds_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign LEDS          = leds_q;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart_tx (
        .CLK   (CLK),
        .RESET (RESET),
        .start (uart_start),
        .data  (bus.mem_wdata[7:0]),
        .busy  (uart_busy),
        .TXD   (TXD)
    );

endmodule
